// File: rtl/aes_pkg.sv
// aes_pkg: shared AES sizes, the frame sequencer state type and the pad helper.
// ST_PAD_BLOCK exists only when AES_FRAME_PKCS7_EN is defined.
`include "aes_defines.svh"

package aes_pkg;

  localparam int AES_BLOCK_BITS  = `AES_BLOCK_SIZE;
  localparam int AES_KEY_BITS    = `AES256_KEY_LENGTH;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY_0 = 3'd1,
    ST_KEY_1 = 3'd2,
    ST_IV    = 3'd3,
    ST_TEXT  = 3'd4,
    ST_PAD   = 3'd5
`ifdef AES_FRAME_PKCS7_EN
    ,
    ST_PAD_BLOCK = 3'd6
`endif
  } frame_state_e;

  // PKCS#7 pad value: number of bytes still missing from the 16-byte block.
  function automatic logic [7:0] pkcs7_pad_byte(input logic [7:0] used_bytes);
    return 8'(AES_BLOCK_BYTES) - used_bytes;
  endfunction

endpackage

// File: rtl/axis_if.sv
// axis_if: minimal AXI-Stream bundle with keep, last and a one-bit user field.
interface axis_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tlast;
  logic               tuser;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/aes_defines.svh
// Shared AES sizing constants used across the AES datapath.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH
`define AES_BLOCK_SIZE    128
`define AES256_KEY_LENGTH 256
`endif

// File: rtl/aes_pad_beat.sv
// aes_pad_beat: replaces every byte lane whose keep bit is clear with the pad byte.
module aes_pad_beat #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  input  logic [7:0]          pad_byte,
  output logic [DATA_W-1:0]   data_out
);

  localparam int KW = DATA_W / 8;

  // Lane-wise substitution; kept lanes pass through untouched.
  always_comb begin
    data_out = data;
    for (int b = 0; b < KW; b++) begin
      if (!keep[b]) begin
        data_out[b*8 +: 8] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/aes256_cbc_frame_tx.sv
// aes256_cbc_frame_tx: turns one payload frame into the CBC engine command stream
// (key low half, key high half, IV, text blocks padded out to a 16-byte boundary).
// Define AES_FRAME_PKCS7_EN for PKCS#7 padding; default build pads with zero bytes.
module aes256_cbc_frame_tx
  import aes_pkg::*;
#(
  parameter int AXIS_WIDTH = 8
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Start,
  input  logic                      Encrypt,
  input  logic [AES_KEY_BITS-1:0]   Key,
  input  logic [AES_BLOCK_BITS-1:0] Iv,
  output logic                      Busy,
  axis_if.slave                     S_axis,
  axis_if.master                    M_axis
);

  localparam int         W        = AXIS_WIDTH;
  localparam int         KW       = W / 8;
  localparam int         N        = AES_BLOCK_BITS / W;
  localparam logic [4:0] LAST_CNT = 5'(N - 1);

  frame_state_e              state_q, state_d;
  logic [4:0]                cnt_q, cnt_d, cnt_next;
  logic [7:0]                pad_q, pad_d;
  logic [AES_KEY_BITS-1:0]   key_q;
  logic [AES_BLOCK_BITS-1:0] iv_q;
  logic                      enc_q;

  logic [W-1:0]              s_data, padded_data, hdr_data, m_data;
  logic [KW-1:0]             s_keep;
  logic                      s_valid, s_last, s_ready;
  logic                      m_valid, m_ready, m_last;
  logic [7:0]                text_pad;
  logic [6:0]                hdr_off;
  logic [AES_BLOCK_BITS-1:0] hdr_word;
  logic                      closes_block, ends_frame;

  assign s_data  = S_axis.tdata;
  assign s_keep  = S_axis.tkeep;
  assign s_valid = S_axis.tvalid;
  assign s_last  = S_axis.tlast;
  assign m_ready = M_axis.tready;

  assign cnt_next     = (cnt_q == LAST_CNT) ? 5'd0 : cnt_q + 5'd1;
  assign closes_block = s_last && (cnt_q == LAST_CNT);

`ifdef AES_FRAME_PKCS7_EN
  logic [7:0] used_bytes;
  // Bytes of the final block consumed by payload: whole earlier beats plus kept lanes.
  assign used_bytes = 8'(cnt_q) * 8'(KW) + 8'($countones(s_keep));
  assign text_pad   = pkcs7_pad_byte(used_bytes);
  // A full block-closing beat still owes a whole pad block, so only a partial one ends here.
  assign ends_frame = closes_block && !(&s_keep);
`else
  assign text_pad   = 8'h00;
  // A partial final beat on the last slot already completes the block with in-beat padding.
  assign ends_frame = closes_block;
`endif

  aes_pad_beat #(
    .DATA_W   (W)
  ) u_pad_beat (
    .data     (s_data),
    .keep     (s_keep),
    .pad_byte (text_pad),
    .data_out (padded_data)
  );

  // Select the latched key/IV word for the current header state and slice out beat cnt_q.
  always_comb begin
    hdr_off = 7'(int'(cnt_q) * W);
    case (state_q)
      ST_KEY_0: hdr_word = key_q[AES_BLOCK_BITS-1:0];
      ST_KEY_1: hdr_word = key_q[AES_KEY_BITS-1:AES_BLOCK_BITS];
      default:  hdr_word = iv_q;
    endcase
    hdr_data = hdr_word[hdr_off +: W];
  end

  // Sequencer next-state, beat counter and stream handshakes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_KEY_0;
          cnt_d   = '0;
        end
      end
      ST_KEY_0, ST_KEY_1, ST_IV: begin
        m_valid = 1'b1;
        m_data  = hdr_data;
        if (m_ready) begin
          cnt_d = cnt_next;
          if (cnt_q == LAST_CNT) begin
            if (state_q == ST_KEY_0) begin
              state_d = ST_KEY_1;
            end else if (state_q == ST_KEY_1) begin
              state_d = ST_IV;
            end else begin
              state_d = ST_TEXT;
            end
          end
        end
      end
      ST_TEXT: begin
        m_valid = s_valid;
        s_ready = m_ready;
        m_data  = s_last ? padded_data : s_data;
        m_last  = ends_frame;
        if (s_valid && m_ready) begin
          cnt_d = cnt_next;
          if (ends_frame) begin
            state_d = ST_IDLE;
          end else if (s_last) begin
            pad_d = text_pad;
`ifdef AES_FRAME_PKCS7_EN
            state_d = closes_block ? ST_PAD_BLOCK : ST_PAD;
`else
            state_d = ST_PAD;
`endif
          end
        end
      end
      ST_PAD: begin
        m_valid = 1'b1;
        m_data  = {KW{pad_q}};
        m_last  = (cnt_q == LAST_CNT);
        if (m_ready) begin
          cnt_d = cnt_next;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end
        end
      end
`ifdef AES_FRAME_PKCS7_EN
      ST_PAD_BLOCK: begin
        m_valid = 1'b1;
        m_data  = {KW{8'(AES_BLOCK_BYTES)}};
        m_last  = (cnt_q == LAST_CNT);
        if (m_ready) begin
          cnt_d = cnt_next;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, beat counter and registered pad byte.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
    end
  end

  // Frame parameters are captured only when a Start is accepted from idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      key_q <= '0;
      iv_q  <= '0;
      enc_q <= 1'b0;
    end else if (state_q == ST_IDLE && Start) begin
      key_q <= Key;
      iv_q  <= Iv;
      enc_q <= Encrypt;
    end
  end

  assign Busy          = (state_q != ST_IDLE);
  assign S_axis.tready = s_ready;
  assign M_axis.tvalid = m_valid;
  assign M_axis.tdata  = m_valid ? m_data : '0;
  assign M_axis.tkeep  = m_valid ? '1 : '0;
  assign M_axis.tlast  = m_valid & m_last;
  assign M_axis.tuser  = m_valid & enc_q;

endmodule

// File: tb/tb_aes256_cbc_frame_tx.sv
// Bench for aes256_cbc_frame_tx at 32-bit beats: table-driven frames and random frames
// checked against a byte-stream model, plus directed reset and padding sequences.
module tb_aes256_cbc_frame_tx;

  localparam int W  = 32;
  localparam int KW = W / 8;

  typedef logic [W+KW+1:0] beat_t;   // {tlast, tuser, tkeep, tdata}

  typedef struct {
    int len;
    bit enc;
    int rdy;      // 0: always ready, 1: random, 2: toggling
    bit mid;      // extra Start pulse mid-frame
    int beats;    // expected number of M beats
  } vec_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic         Encrypt;
  logic [255:0] Key;
  logic [127:0] Iv;
  logic         Busy;

  axis_if #(.WIDTH(W)) s_if ();
  axis_if #(.WIDTH(W)) m_if ();

  aes256_cbc_frame_tx #(
    .AXIS_WIDTH (W)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Encrypt (Encrypt),
    .Key     (Key),
    .Iv      (Iv),
    .Busy    (Busy),
    .S_axis  (s_if),
    .M_axis  (m_if)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  byte unsigned payload[$];
  beat_t        exp_q[$];
  logic [W-1:0] rx_q[$];
  logic         rxl_q[$];
  vec_t         vt[10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rx(input string name, input int idx, input logic [W-1:0] d, input logic l);
    if (idx < rx_q.size()) chk(name, {rxl_q[idx], rx_q[idx]}, {l, d});
    else chk({name, " present"}, rx_q.size(), idx + 1);
  endtask

  // Reference: the whole frame as a byte stream, padded to a block, cut into beats.
  task automatic build_expected(input logic [255:0] k, input logic [127:0] v, input bit enc);
    byte unsigned s[$];
    int r, nb;
    logic [W-1:0] d;
    for (int i = 0; i < 32; i++) s.push_back(k[8*i +: 8]);
    for (int i = 0; i < 16; i++) s.push_back(v[8*i +: 8]);
    foreach (payload[i]) s.push_back(payload[i]);
    r = payload.size() % 16;
`ifdef AES_FRAME_PKCS7_EN
    for (int i = 0; i < 16 - r; i++) s.push_back(byte'(16 - r));
`else
    if (r != 0) for (int i = 0; i < 16 - r; i++) s.push_back(8'h00);
`endif
    exp_q.delete();
    nb = s.size() / KW;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < KW; j++) d[8*j +: 8] = s[b*KW + j];
      exp_q.push_back({(b == nb - 1), enc, {KW{1'b1}}, d});
    end
  endtask

  task automatic load_s(input int j, input int len, input int nb);
    logic [W-1:0]  d;
    logic [KW-1:0] kp;
    for (int k = 0; k < KW; k++) begin
      if (j*KW + k < len) begin
        d[8*k +: 8] = payload[j*KW + k];
        kp[k] = 1'b1;
      end else begin
        d[8*k +: 8] = 8'($urandom);
        kp[k] = 1'b0;
      end
    end
    s_if.tdata = d;
    s_if.tkeep = kp;
    s_if.tlast = (j == nb - 1);
    s_if.tuser = 1'b0;
  endtask

  task automatic run_frame(input string name, input int len, input bit enc, input int rdy,
                           input bit mid, input bit fixed, input int exp_beats);
    logic [255:0] k;
    logic [127:0] v;
    int nb_in, s_idx, s_cnt, got, cyc, busy_drop, zero_viol;
    bit done, s_take;
    beat_t act;
    if (fixed) begin
      for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
      for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(8'hA0 + i);
    end else begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
    end
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(fixed ? byte'(8'h11 + i) : byte'($urandom_range(0, 255)));
    build_expected(k, v, enc);
    rx_q.delete();
    rxl_q.delete();
    nb_in = (len + KW - 1) / KW;

    @(posedge Clk); #1;
    Key = k; Iv = v; Encrypt = enc; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Key = ~k; Iv = ~v; Encrypt = ~enc;
    m_if.tready = (rdy == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    s_idx = 0; s_cnt = 0; got = 0; cyc = 0; busy_drop = 0; zero_viol = 0; done = 0;
    load_s(0, len, nb_in);
    s_if.tvalid = 1'b1;

    while (!done && cyc < 2000) begin
      @(negedge Clk);
      if (!Busy) busy_drop++;
      if (!m_if.tvalid && (m_if.tdata != '0 || m_if.tkeep != '0 || m_if.tlast || m_if.tuser))
        zero_viol++;
      if (m_if.tvalid && m_if.tready) begin
        act = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
        rx_q.push_back(m_if.tdata);
        rxl_q.push_back(m_if.tlast);
        if (got < exp_q.size()) chk($sformatf("%s beat%0d", name, got), act, exp_q[got]);
        else chk($sformatf("%s excess beats", name), got + 1, exp_q.size());
        got++;
        if (m_if.tlast || got > exp_q.size() + 4) done = 1;
      end
      s_take = s_if.tvalid && s_if.tready;
      if (s_take) s_cnt++;
      @(posedge Clk); #1;
      cyc++;
      if (s_take) s_idx++;
      if (s_idx >= nb_in) s_if.tvalid = 1'b0;
      else if (s_take || !s_if.tvalid) begin
        s_if.tvalid = ($urandom_range(0, 3) != 0);
        if (s_if.tvalid) load_s(s_idx, len, nb_in);
      end
      if (mid && cyc == 3) begin
        Start = 1'b1;
        Key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        Iv = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        Start = 1'b0;
      end
      case (rdy)
        0: m_if.tready = 1'b1;
        1: m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = (cyc % 2 == 0);
      endcase
    end

    chk({name, " tlast seen"}, done, 1);
    if (exp_beats >= 0) chk({name, " beat count"}, got, exp_beats);
    chk({name, " payload consumed"}, s_cnt, nb_in);
    chk({name, " Busy held"}, busy_drop, 0);
    chk({name, " idle fields zero"}, zero_viol, 0);
    @(posedge Clk); #1;
    s_if.tvalid = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    chk({name, " Busy after"}, Busy, 0);
    chk({name, " tvalid after"}, m_if.tvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef AES_FRAME_PKCS7_EN
    vt[0] = '{16, 1'b1, 0, 1'b0, 20};
    vt[3] = '{32, 1'b0, 1, 1'b0, 24};
    vt[8] = '{48, 1'b1, 2, 1'b1, 28};
`else
    vt[0] = '{16, 1'b1, 0, 1'b0, 16};
    vt[3] = '{32, 1'b0, 1, 1'b0, 20};
    vt[8] = '{48, 1'b1, 2, 1'b1, 24};
`endif
    vt[1] = '{5,  1'b0, 0, 1'b0, 16};
    vt[2] = '{6,  1'b1, 1, 1'b0, 16};
    vt[4] = '{1,  1'b1, 2, 1'b0, 16};
    vt[5] = '{15, 1'b0, 1, 1'b0, 16};
    vt[6] = '{12, 1'b1, 0, 1'b0, 16};
    vt[7] = '{17, 1'b0, 1, 1'b0, 20};
    vt[9] = '{13, 1'b1, 2, 1'b1, 16};

    Rst = 1'b1; Start = 1'b1; Encrypt = 1'b1; Key = '1; Iv = '1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;

    // Reset state, with Start held high during reset
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset Busy", Busy, 0);
    chk("reset M tvalid", m_if.tvalid, 0);
    chk("reset S tready", s_if.tready, 0);
    @(posedge Clk); #1;
    Rst = 1'b0; Start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("post-reset Busy", Busy, 0);
    chk("post-reset M tvalid", m_if.tvalid, 0);

    // Directed: known key/IV, 16-byte payload
    run_frame("known16", 16, 1'b1, 0, 1'b0, 1'b1, -1);
    chk_rx("known16 key beat0", 0, 32'h03020100, 1'b0);
    chk_rx("known16 key beat7", 7, 32'h1F1E1D1C, 1'b0);
    chk_rx("known16 iv beat0", 8, 32'hA3A2A1A0, 1'b0);
    chk_rx("known16 text0", 12, 32'h14131211, 1'b0);
`ifdef AES_FRAME_PKCS7_EN
    chk_rx("known16 text3", 15, 32'h201F1E1D, 1'b0);
    chk_rx("known16 padblk", 19, 32'h10101010, 1'b1);
`else
    chk_rx("known16 text3", 15, 32'h201F1E1D, 1'b1);
`endif

    // Directed: 6-byte payload, partial last beat at block slot 1
    run_frame("part6", 6, 1'b0, 0, 1'b0, 1'b1, 16);
`ifdef AES_FRAME_PKCS7_EN
    chk_rx("part6 last beat", 13, 32'h0A0A1615, 1'b0);
    chk_rx("part6 pad0", 14, 32'h0A0A0A0A, 1'b0);
    chk_rx("part6 pad1", 15, 32'h0A0A0A0A, 1'b1);
`else
    chk_rx("part6 last beat", 13, 32'h00001615, 1'b0);
    chk_rx("part6 pad0", 14, 32'h00000000, 1'b0);
    chk_rx("part6 pad1", 15, 32'h00000000, 1'b1);
`endif

    // Table-driven frames
    for (int i = 0; i < 10; i++)
      run_frame($sformatf("vec%0d", i), vt[i].len, vt[i].enc, vt[i].rdy, vt[i].mid, 1'b0, vt[i].beats);

    // Reset during the IV phase abandons the frame
    @(posedge Clk); #1;
    for (int i = 0; i < 32; i++) Key[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) Iv[8*i +: 8] = 8'(8'hA0 + i);
    Encrypt = 1'b1; Start = 1'b1; m_if.tready = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    chk("rstiv in IV", {Busy, m_if.tvalid, m_if.tdata}, {1'b1, 1'b1, 32'hA7A6A5A4});
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("rstiv Busy", Busy, 0);
    chk("rstiv M tvalid", m_if.tvalid, 0);
    chk("rstiv M tlast", m_if.tlast, 0);
    chk("rstiv S tready", s_if.tready, 0);
    run_frame("after rst", 8, 1'b1, 1, 1'b0, 1'b1, 16);
    chk_rx("after rst key beat0", 0, 32'h03020100, 1'b0);

    // Random frames against the model
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("rnd%0d", i), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes256_cbc_frame_tx.md
AES256_CBC_FRAME_TX -- requirements
Module: aes256_cbc_frame_tx

Interface
REQ-001 SHALL have parameter AXIS_WIDTH, default 8, beat width in bits; legal values are 8, 16, 32, 64 or 128.
REQ-002 SHALL have ports Clk, input, 1 -- the single clock; all logic on its rising edge.
REQ-003 SHALL have port Rst, input, 1 -- synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 -- one-cycle frame request; honoured only in ST_IDLE.
REQ-005 SHALL have port Encrypt, input, 1 -- direction, latched at Start.
REQ-006 SHALL have port Key, input, 256 -- AES-256 key, latched at Start.
REQ-007 SHALL have port Iv, input, 128 -- CBC IV, latched at Start.
REQ-008 SHALL have port Busy, output, 1 -- high whenever the state is not ST_IDLE.
REQ-009 SHALL have port S_axis, axis_if.slave, AXIS_WIDTH -- plaintext/ciphertext payload; tkeep is honoured only on the tlast beat.
REQ-010 SHALL have port M_axis, axis_if.master, AXIS_WIDTH -- command stream to the CBC engine: key, IV, then text blocks.

Function
REQ-011 SHALL implement states ST_IDLE, ST_KEY_0, ST_KEY_1, ST_IV, ST_TEXT and ST_PAD, plus ST_PAD_BLOCK when REQ-030 is enabled.
REQ-012 SHALL move ST_IDLE->ST_KEY_0 on Start and latch Key, Iv and Encrypt in the same cycle.
REQ-013 SHALL emit N=128/AXIS_WIDTH beats in each of ST_KEY_0, ST_KEY_1 and ST_IV, then advance to the next state.
REQ-014 SHALL source the key/IV beat data as follows:
- ST_KEY_0 beat i carries Key[i*W +: W].
- ST_KEY_1 beat i carries Key[128+i*W +: W].
- ST_IV beat i carries Iv[i*W +: W].
REQ-015 SHALL hold M_axis.tvalid=1 and S_axis.tready=0 in the key/IV states; a beat advances only on M_axis.tvalid&tready.
REQ-016 SHALL apply these M_axis field values:
- tuser = latched Encrypt on every beat.
- tkeep = all ones on every beat.
- tlast = 0 on every beat except the final text beat.
REQ-017 SHALL make ST_TEXT a combinational pass-through: M.tvalid=S.tvalid, S.tready=M.tready, no added latency.
REQ-018 SHALL keep a block beat counter 0..N-1 that increments per transferred text or pad beat and wraps at N-1.
REQ-019 SHALL replace the bytes of an S tlast beat whose tkeep bit is 0 with the pad byte; tkeep is assumed low-contiguous.
REQ-020 SHALL handle an S tlast beat that is full and lands on counter N-1 by forwarding it with M.tlast=1 and returning to ST_IDLE.
REQ-021 SHALL handle an S tlast beat that is partial or lands on counter<N-1 as follows:
- force M.tlast=0 on that beat;
- enter ST_PAD;
- emit pad-only beats (S.tready=0) up to counter N-1;
- assert tlast on the last pad beat, then go to ST_IDLE.
REQ-022 SHALL use a default pad byte of 8'h00.
REQ-023 SHALL ignore Start while Busy, with no effect on latched values.
REQ-024 SHALL drive these values on M_axis whenever M.tvalid=0: tdata=0, tkeep=0, tlast=0, tuser=0.

Reset
REQ-025 SHALL on Rst put the state in ST_IDLE and clear the beat counter and all latched registers to 0.
REQ-026 SHALL hold Busy=0, M.tvalid=0 and S.tready=0 during and after reset until Start.
REQ-027 SHALL, when reset is asserted mid-frame, abandon the frame without emitting tlast; the downstream engine is reset alongside.

Configuration
REQ-028 SHALL gate PKCS#7 padding with the macro AES_FRAME_PKCS7_EN.
REQ-029 SHALL, without the macro, use zero padding per REQ-021/022 and add no extra block on aligned payloads.
REQ-030 SHALL, with the macro defined, apply PKCS#7 padding as follows:
- pad byte = 16 - (bytes used in the final block), range 1..16, registered on entering ST_PAD.
- an aligned payload (REQ-020 case) forwards the last beat with tlast=0, then enters ST_PAD_BLOCK.
- ST_PAD_BLOCK emits N beats of 8'h10, with tlast on the last beat.

Structure
REQ-031 SHALL take AES_BLOCK_SIZE and AES256_KEY_LENGTH from the shared aes_defines.svh.
REQ-032 SHALL place the state enum typedef and an AES_BLOCK_BYTES=16 constant in the shared package aes_pkg.
REQ-033 SHALL implement byte masking and pad substitution in the sub-module aes_pad_beat (inputs: data, keep, pad byte).

Verification
REQ-034 Case W=8, Key=0..1F bytes, Iv=A0..AF, Encrypt=1, 16-byte payload -> 64 beats: key bytes 00..1F, IV bytes A0..AF, payload unchanged, tlast only on beat 63, tuser=1 on all beats.
REQ-035 Case W=8, 5-byte payload, no macro -> 5 payload beats, then 11 beats of 00, tlast on the 16th text beat.
REQ-036 Case W=32, last beat tkeep=4'b0011 at counter 1, macro on -> that beat's bytes 2-3 = 0A, then 2 beats of 0A0A0A0A, tlast on the last one.
REQ-037 Case 32-byte aligned payload, macro on -> 32 payload bytes, then 16 bytes of 10, tlast only on the final pad beat.
REQ-038 Case M.tready toggling 1010... plus a Start pulse mid-frame -> data order intact, latched Key unchanged, Busy stays 1.
REQ-039 Case Rst asserted during ST_IV -> next cycle ST_IDLE, Busy=0, M.tvalid=0; a new Start replays the key from beat 0.
